// File: rtl/spart_echo_ctrl.sv
// rtl/spart_echo_ctrl.sv - SPART echo controller with divisor load and receive FIFO
//
// Programs the SPART baud divisor, then moves received bytes through a
// circular FIFO back out to the transmitter, with optional ASCII case swap.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   br_cfg     : baud select (00..11 -> DIV0..DIV3), sampled every cycle
//   mode       : 00 echo, 01 echo with case swap, 10 sink, 11 hold
//   rda        : SPART receive data available
//   tbr        : SPART transmit buffer ready
//   iocs       : SPART chip select
//   iorw       : 1 = read, 0 = write
//   ioaddr     : 00 data, 10 divisor low, 11 divisor high
//   databus    : bidirectional data, driven only on writes
//   fifo_count : bytes held in the FIFO
//   fifo_full  : fifo_count == DEPTH
//   cfg_busy   : divisor load in progress

module spart_echo_ctrl #(
  // DEPTH must be a power of two, at least 2; the pointers rely on natural wrap.
  parameter int          DEPTH = 8,
  parameter logic [15:0] DIV0  = 16'd10416,
  parameter logic [15:0] DIV1  = 16'd5208,
  parameter logic [15:0] DIV2  = 16'd2604,
  parameter logic [15:0] DIV3  = 16'd1302
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               br_cfg,
  input  logic [1:0]               mode,
  input  logic                     rda,
  input  logic                     tbr,
  output logic                     iocs,
  output logic                     iorw,
  output logic [1:0]               ioaddr,
  inout  wire  [7:0]               databus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     cfg_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_SINK = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_DLO  = 2'b10;
  localparam logic [1:0] ADDR_DHI  = 2'b11;

  typedef enum logic [1:0] {
    CFG_LO = 2'd0,
    CFG_HI = 2'd1,
    RUN    = 2'd2,
    WR_GAP = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [1:0]      cfg_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [15:0]     divisor;
  logic [7:0]      head;
  logic [7:0]      head_xf;
  logic [7:0]      bus_out;
  logic            do_read;
  logic            do_write;
  logic            do_push;
  logic            is_alpha;

  // Divisor follows br_cfg combinationally so a reload always uses the
  // selection present while the bytes are actually on the bus.
  always_comb begin
    divisor = DIV0;
    case (br_cfg)
      2'b00: divisor = DIV0;
      2'b01: divisor = DIV1;
      2'b10: divisor = DIV2;
      2'b11: divisor = DIV3;
    endcase
  end

  assign head = mem[rd_ptr];

  // Upper and lower ASCII letters differ only in bit 5.
  assign is_alpha = ((head >= 8'h41) && (head <= 8'h5A)) ||
                    ((head >= 8'h61) && (head <= 8'h7A));

  always_comb begin
    head_xf = head;
    if ((mode == MODE_SWAP) && is_alpha) begin
      head_xf[5] = ~head[5];
    end
  end

  assign fifo_count = count;
  assign fifo_full  = (count == CW'(DEPTH));
  assign cfg_busy   = (state == CFG_LO) || (state == CFG_HI);

  // One bus transaction per cycle: a pending baud change wins, then a read,
  // then a write. Reads beat writes so the SPART receiver never overruns.
  always_comb begin
    state_nx = state;
    iocs     = 1'b0;
    iorw     = 1'b0;
    ioaddr   = ADDR_DATA;
    bus_out  = 8'h00;
    do_read  = 1'b0;
    do_write = 1'b0;
    case (state)
      CFG_LO: begin
        iocs     = 1'b1;
        ioaddr   = ADDR_DLO;
        bus_out  = divisor[7:0];
        state_nx = CFG_HI;
      end
      CFG_HI: begin
        iocs     = 1'b1;
        ioaddr   = ADDR_DHI;
        bus_out  = divisor[15:8];
        state_nx = RUN;
      end
      RUN: begin
        if (br_cfg != cfg_q) begin
          state_nx = CFG_LO;
        end else if (rda && !fifo_full && (mode != MODE_HOLD)) begin
          iocs    = 1'b1;
          iorw    = 1'b1;
          do_read = 1'b1;
        end else if (tbr && (count != '0) && (mode != MODE_SINK)) begin
          iocs     = 1'b1;
          bus_out  = head_xf;
          do_write = 1'b1;
          state_nx = WR_GAP;
        end
      end
      WR_GAP: begin
        // tbr may still read high for a cycle after a write lands.
        state_nx = RUN;
      end
    endcase
  end

  // Sink mode still reads the SPART so its receiver drains, but drops the byte.
  assign do_push = do_read && (mode != MODE_SINK);

  assign databus = (iocs && !iorw) ? bus_out : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CFG_LO;
      cfg_q  <= 2'b00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (state == CFG_HI) begin
        cfg_q <= br_cfg;
      end
      // do_push and do_write are mutually exclusive by construction.
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (do_write) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset; only locations below count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= databus;
    end
  end

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// tb/tb_spart_echo_ctrl.sv - scoreboard bench for spart_echo_ctrl

module tb_spart_echo_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b00;
  logic [1:0] mode = 2'b00;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       cfg_busy;

  logic [7:0] rx_data = 8'h00;
  logic [7:0] rx_q [$];
  logic [7:0] mf [$];

  int n_vec = 0;
  int n_err = 0;

  spart_echo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .mode(mode), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .cfg_busy(cfg_busy)
  );

  // SPART side of the bus: supplies the pending receive byte on reads.
  assign databus = (iocs && iorw) ? rx_data : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] s);
    case (s)
      2'd0: return 16'd10416;
      2'd1: return 16'd5208;
      2'd2: return 16'd2604;
      default: return 16'd1302;
    endcase
  endfunction

  function automatic logic [7:0] swap_ref(input logic [7:0] b, input logic [1:0] m);
    if (m == 2'b01 && b >= 8'd65 && b <= 8'd90) return b + 8'd32;
    if (m == 2'b01 && b >= 8'd97 && b <= 8'd122) return b - 8'd32;
    return b;
  endfunction

  function automatic void refresh_rx();
    rda = (rx_q.size() != 0);
    rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  task automatic put(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: reference model of the controller's transaction rules,
  // evaluated at each falling edge for the action due on the next rising edge.
  initial begin : monitor
    int         ph;
    logic [1:0] cfg_m;
    logic       pop_rx;
    logic [15:0] d;
    logic [7:0] exp_b;
    ph = 0;
    cfg_m = 2'b00;
    forever begin
      @(negedge clk);
      pop_rx = 1'b0;
      if (!rst) begin
        mf.delete();
        ph = 0;
        cfg_m = 2'b00;
        chk("rst_count", fifo_count, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_iocs", iocs, 1);
        chk("rst_iorw", iorw, 0);
        chk("rst_addr", ioaddr, 2);
        chk("rst_busy", cfg_busy, 1);
      end else begin
        chk("count", fifo_count, mf.size());
        chk("full", fifo_full, mf.size() == DEPTH);
        chk("busy", cfg_busy, ph < 2);
        d = div_of(br_cfg);
        case (ph)
          0: begin
            chk("cfglo_bus", {iocs, iorw, ioaddr}, 4'b1010);
            chk("cfglo_data", databus, d[7:0]);
            ph = 1;
          end
          1: begin
            chk("cfghi_bus", {iocs, iorw, ioaddr}, 4'b1011);
            chk("cfghi_data", databus, d[15:8]);
            cfg_m = br_cfg;
            ph = 2;
          end
          3: begin
            chk("gap_iocs", iocs, 0);
            ph = 2;
          end
          default: begin
            if (br_cfg != cfg_m) begin
              chk("reload_idle", iocs, 0);
              ph = 0;
            end else if (rda && mf.size() < DEPTH && mode != 2'b11) begin
              chk("rd_bus", {iocs, iorw, ioaddr}, 4'b1100);
              if (mode != 2'b10) mf.push_back(rx_data);
              pop_rx = 1'b1;
            end else if (tbr && mf.size() > 0 && mode != 2'b10) begin
              exp_b = swap_ref(mf[0], mode);
              chk("wr_bus", {iocs, iorw, ioaddr}, 4'b1000);
              chk("wr_data", databus, exp_b);
              void'(mf.pop_front());
              ph = 3;
            end else begin
              chk("idle_bus", {iocs, iorw, ioaddr}, 4'b0000);
            end
          end
        endcase
      end
      @(posedge clk);
      #1;
      if (pop_rx) begin
        void'(rx_q.pop_front());
        refresh_rx();
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int  w;
    int  found;
    refresh_rx();
    rst = 1'b0;
    br_cfg = 2'b01;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    chk("run_after_cfg", cfg_busy, 0);

    // Verbatim echo of two bytes.
    mode = 2'b00;
    put(8'h41);
    put(8'h62);
    cyc(4);
    chk("two_buffered", fifo_count, 2);
    tbr = 1'b1;
    cyc(8);
    chk("two_drained", fifo_count, 0);

    // Case swap.
    mode = 2'b01;
    put(8'h41);
    put(8'h7A);
    put(8'h31);
    cyc(12);
    chk("swap_drained", fifo_count, 0);

    // Fill to full; ninth byte must stay pending; then drain across wrap.
    tbr = 1'b0;
    mode = 2'b00;
    for (int i = 0; i < 9; i++) put(8'h30 + 8'(i));
    cyc(15);
    chk("full_after8", fifo_full, 1);
    chk("ninth_pending", rx_q.size(), 1);
    tbr = 1'b1;
    cyc(40);
    chk("nine_rx_done", rx_q.size(), 0);
    chk("nine_drained", fifo_count, 0);

    // Read wins over write in the same cycle.
    tbr = 1'b0;
    put(8'hA5);
    cyc(3);
    put(8'h5A);
    tbr = 1'b1;
    @(negedge clk);
    chk("prio_read", {iocs, iorw, ioaddr}, 4'b1100);
    cyc(10);
    tbr = 1'b0;

    // Baud change with bytes buffered.
    br_cfg = 2'b00;
    cyc(5);
    put(8'hC1);
    put(8'hC2);
    put(8'hC3);
    cyc(6);
    br_cfg = 2'b11;
    cyc(4);
    chk("kept_over_reload", fifo_count, 3);
    tbr = 1'b1;
    cyc(12);
    chk("reload_drained", fifo_count, 0);

    // Reset in the middle of a write cycle.
    tbr = 1'b0;
    put(8'h11);
    put(8'h22);
    put(8'h33);
    put(8'h44);
    cyc(8);
    tbr = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) found = 1;
    end
    chk("found_write", found, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midwr_count", fifo_count, 0);
    chk("midwr_busy", cfg_busy, 1);
    chk("midwr_bus", {iocs, iorw, ioaddr}, 4'b1010);
    cyc(2);
    rst = 1'b1;
    cyc(20);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && rx_q.size() < 12) put(8'($urandom));
      tbr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) br_cfg = 2'($urandom_range(0, 3));
      cyc(1);
    end

    mode = 2'b00;
    tbr = 1'b1;
    w = 0;
    while ((rx_q.size() != 0 || fifo_count != 0) && w < 500) begin
      cyc(1);
      w++;
    end
    chk("drain_bounded", w < 500, 1);
    chk("final_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
